// File: rtl/ps2_mouse_sequencer_if.sv
// Byte-level bus between the PS/2 mouse sequencer, the byte transceiver and user logic.
// master = sequencer side, slave = transceiver/user side.
interface ps2_mouse_sequencer_if;
  logic [7:0] Rx_Byte;
  logic       Rx_Valid;
  logic [7:0] Tx_Byte;
  logic       Tx_Start;
  logic       Tx_Done;
  logic       Tx_Err;
  logic       Init_Done;
  logic       Init_Err;
  logic       Pkt_Valid;
  logic [2:0] Btn;
  logic [8:0] Dx;
  logic [8:0] Dy;
  logic [1:0] Ovf;

  modport master (
    input  Rx_Byte, Rx_Valid, Tx_Done, Tx_Err,
    output Tx_Byte, Tx_Start, Init_Done, Init_Err, Pkt_Valid, Btn, Dx, Dy, Ovf
  );
  modport slave (
    output Rx_Byte, Rx_Valid, Tx_Done, Tx_Err,
    input  Tx_Byte, Tx_Start, Init_Done, Init_Err, Pkt_Valid, Btn, Dx, Dy, Ovf
  );
endinterface

// File: rtl/ps2_mouse_sequencer.sv
// PS/2 mouse host sequencer: init handshake with retry/timeout, then 3-byte packet assembly.
// Optional PS2_SYNC_CHECK_EN: drop stream byte 0 whose bit3 is clear to regain packet alignment.
module ps2_mouse_sequencer #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TIMEOUT_CYC = CLK_HZ / 2,
  parameter int PKT_GAP_CYC = CLK_HZ / 500,
  parameter int MAX_RETRY   = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  ps2_mouse_sequencer_if.master bus
);
  localparam int CNT_MAX = (TIMEOUT_CYC > PKT_GAP_CYC) ? TIMEOUT_CYC : PKT_GAP_CYC;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    S_SEND_RST, S_WAIT_TX, S_ACK1, S_BAT, S_ID, S_SEND_EN, S_ACK2, S_STREAM, S_ERROR
  } state_t;

  state_t        r_state;
  logic          r_cmd_en;   // command in flight is 0xF4 (else 0xFF)
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_retry;
  logic [1:0]    r_idx;
  logic [7:0]    r_b0, r_b1;
  logic [7:0]    r_tx_byte;
  logic          r_tx_start, r_init_done, r_init_err, r_pkt_valid;
  logic [2:0]    r_btn;
  logic [8:0]    r_dx, r_dy;
  logic [1:0]    r_ovf;

  logic   w_rx, w_tmo, w_gap_exp, w_fail;
  logic [7:0] w_exp;
  logic [1:0] w_idx;
  state_t w_fail_tgt;

  assign w_rx      = bus.Rx_Valid;
  assign w_tmo     = (r_cnt == CW'(TIMEOUT_CYC - 1));
  assign w_gap_exp = (r_idx != 2'd0) && (r_cnt == CW'(PKT_GAP_CYC - 1));
  assign w_idx     = w_gap_exp ? 2'd0 : r_idx;

  always_comb begin
    w_fail     = 1'b0;
    w_fail_tgt = S_SEND_RST;
    w_exp      = 8'hFA;
    case (r_state)
      S_BAT:   w_exp = 8'hAA;
      S_ID:    w_exp = 8'h00;
      default: w_exp = 8'hFA;
    endcase
    case (r_state)
      S_WAIT_TX: w_fail = bus.Tx_Err || (!bus.Tx_Done && w_tmo);
      S_ACK1, S_BAT, S_ID, S_ACK2: begin
        w_fail = w_rx ? (bus.Rx_Byte != w_exp) : w_tmo;
        // A resend request during ACK2 repeats only the enable command
        if (r_state == S_ACK2 && w_rx && bus.Rx_Byte == 8'hFE) w_fail_tgt = S_SEND_EN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_SEND_RST;
      r_cmd_en    <= 1'b0;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_idx       <= 2'd0;
      r_b0        <= 8'h00;
      r_b1        <= 8'h00;
      r_tx_byte   <= 8'h00;
      r_tx_start  <= 1'b0;
      r_init_done <= 1'b0;
      r_init_err  <= 1'b0;
      r_pkt_valid <= 1'b0;
      r_btn       <= 3'd0;
      r_dx        <= 9'd0;
      r_dy        <= 9'd0;
      r_ovf       <= 2'd0;
    end else begin
      r_tx_start  <= 1'b0;
      r_pkt_valid <= 1'b0;
      if (w_fail) begin
        r_retry <= r_retry + 1'b1;
        r_cnt   <= '0;
        if (r_retry == RW'(MAX_RETRY - 1)) begin
          r_state    <= S_ERROR;
          r_init_err <= 1'b1;
        end else begin
          r_state <= w_fail_tgt;
        end
      end else begin
        case (r_state)
          S_SEND_RST, S_SEND_EN: begin
            r_cmd_en   <= (r_state == S_SEND_EN);
            r_tx_byte  <= (r_state == S_SEND_EN) ? 8'hF4 : 8'hFF;
            r_tx_start <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_WAIT_TX;
          end
          S_WAIT_TX: begin
            if (bus.Tx_Done) begin
              r_cnt   <= '0;
              r_state <= r_cmd_en ? S_ACK2 : S_ACK1;
            end else begin
              r_cnt <= w_rx ? '0 : r_cnt + 1'b1;
            end
          end
          S_ACK1, S_BAT, S_ID, S_ACK2: begin
            if (w_rx) begin
              r_cnt <= '0;
              case (r_state)
                S_ACK1:  r_state <= S_BAT;
                S_BAT:   r_state <= S_ID;
                S_ID:    r_state <= S_SEND_EN;
                default: begin
                  r_state     <= S_STREAM;
                  r_init_done <= 1'b1;
                  r_idx       <= 2'd0;
                end
              endcase
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_STREAM: begin
            if (w_rx) begin
              r_cnt <= '0;
              case (w_idx)
                2'd0: begin
`ifdef PS2_SYNC_CHECK_EN
                  r_b0  <= bus.Rx_Byte;
                  r_idx <= bus.Rx_Byte[3] ? 2'd1 : 2'd0;
`else
                  r_b0  <= bus.Rx_Byte;
                  r_idx <= 2'd1;
`endif
                end
                2'd1: begin
                  r_b1  <= bus.Rx_Byte;
                  r_idx <= 2'd2;
                end
                2'd2: begin
                  r_btn       <= r_b0[2:0];
                  r_dx        <= {r_b0[4], r_b1};
                  r_dy        <= {r_b0[5], bus.Rx_Byte};
                  r_ovf       <= r_b0[7:6];
                  r_pkt_valid <= 1'b1;
                  r_idx       <= 2'd0;
                end
                default: r_idx <= 2'd0;
              endcase
            end else if (w_gap_exp) begin
              r_idx <= 2'd0;
              r_cnt <= '0;
            end else if (r_idx != 2'd0) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.Tx_Byte   = r_tx_byte;
  assign bus.Tx_Start  = r_tx_start;
  assign bus.Init_Done = r_init_done;
  assign bus.Init_Err  = r_init_err;
  assign bus.Pkt_Valid = r_pkt_valid;
  assign bus.Btn       = r_btn;
  assign bus.Dx        = r_dx;
  assign bus.Dy        = r_dy;
  assign bus.Ovf       = r_ovf;
endmodule
